mul_seq_32bit: RTL and testbench

MUL_SEQ_32BIT -- requirements
Module: mul_seq_32bit

---
 rtl/mul_seq_32bit.sv | 113 +++++++++++
 tb/tb_mul_seq_32bit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mul_seq_32bit.sv
// ============================================================================
//  Module      : mul_seq_32bit (with its adder_32bit accumulator)
//  Description : 32x32 -> 64 unsigned shift-add multiplier, one bit per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_32bit (
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Cin,
   output logic [31:0] Sum,
   output logic        Cout
);

   logic [32:0] w_carry;

   assign w_carry[0] = Cin;

   for (genvar i = 0; i < 32; i++) begin : g_bit
      assign Sum[i]       = A[i] ^ B[i] ^ w_carry[i];
      assign w_carry[i+1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
   end

   assign Cout = w_carry[32];

endmodule

module mul_seq_32bit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [63:0] Product
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_m;
   logic [63:0] r_p;
   logic [5:0]  r_cnt;

   logic [31:0] w_sum;
   logic        w_cout;
   logic [63:0] w_p_next;

   adder_32bit u_adder (
      .A    (r_p[63:32]),
      .B    (r_m),
      .Cin  (1'b0),
      .Sum  (w_sum),
      .Cout (w_cout)
   );

   // The adder carry lands in P[63], so no bit of the partial product is lost.
   assign w_p_next = r_p[0] ? {w_cout, w_sum, r_p[31:1]}
                            : {1'b0, r_p[63:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_m     <= 32'h0;
         r_p     <= 64'h0;
         r_cnt   <= 6'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         Product <= 64'h0;
      end else begin
         case (r_state)
            RUN: begin
               r_p   <= w_p_next;
               r_cnt <= r_cnt + 6'd1;
               if (r_cnt == 6'd31) begin
                  r_state <= DONE;
                  Product <= w_p_next;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            IDLE, DONE: begin
               if (start) begin
                  r_state <= RUN;
                  r_m     <= A;
                  r_p     <= {32'h0, B};
                  r_cnt   <= 6'd0;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end else begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_32bit.sv
// ============================================================================
//  Module      : tb_mul_seq_32bit
//  Description : Directed self-checking bench for mul_seq_32bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_seq_32bit;

   logic        clk;
   logic        r_rst_n;
   logic        r_start;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic        w_busy;
   logic        w_done;
   logic [63:0] w_product;

   int          n_checks;
   int          n_errors;
   logic [63:0] r_last_prod;

   mul_seq_32bit dut (
      .clk     (clk),
      .rst_n   (r_rst_n),
      .start   (r_start),
      .A       (r_a),
      .B       (r_b),
      .busy    (w_busy),
      .done    (w_done),
      .Product (w_product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called on a falling edge; start is seen by the next rising edge (t0).
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int repulse_at);
      int busy_n, done_n, prod_chg;
      busy_n = 0; done_n = 0; prod_chg = 0;
      r_a = a; r_b = b; r_start = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         if (w_busy) busy_n++;
         if (w_done) done_n++;
         if (w_product !== r_last_prod) prod_chg++;
         r_a = $urandom;
         r_b = $urandom;
         if (i == repulse_at) begin
            r_a = 32'd9; r_b = 32'd9; r_start = 1'b1;
         end else begin
            r_start = 1'b0;
         end
         @(negedge clk);
      end
      r_start = 1'b0;
      chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd32);
      chk({tag, "_early_done"},  64'(done_n), 64'd0);
      chk({tag, "_prod_held"},   64'(prod_chg), 64'd0);
      chk({tag, "_done"},        64'(w_done), 64'd1);
      chk({tag, "_busy_at_done"}, 64'(w_busy), 64'd0);
      chk({tag, "_product"},     w_product, exp);
      r_last_prod = exp;
      @(negedge clk);
      chk({tag, "_done_pulse"},  64'(w_done), 64'd0);
   endtask

   initial begin
      int busy_n, done_n, gap_n;
      n_checks = 0; n_errors = 0;
      r_last_prod = 64'h0;
      r_rst_n = 1'b0; r_start = 1'b0; r_a = 32'h0; r_b = 32'h0;
      #1;
      chk("rst_busy",    64'(w_busy), 64'd0);
      chk("rst_done",    64'(w_done), 64'd0);
      chk("rst_product", w_product,   64'h0);
      @(negedge clk);
      r_rst_n = 1'b1;

      run_op("m3x5",  32'd3,         32'd5,         64'h0000_0000_0000_000F, -1);
      run_op("mFxF",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1);
      run_op("m0xDB", 32'h0,         32'hDEAD_BEEF, 64'h0, -1);
      run_op("m8x2",  32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000, -1);
      run_op("m7x6",  32'd7,         32'd6,         64'd42, 9);

      // Back-to-back: start held high, expect DONE followed directly by RUN.
      r_a = 32'd2; r_b = 32'd3; r_start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         busy_n = 0; done_n = 0; gap_n = 0;
         for (int i = 0; i < 32; i++) begin
            if (w_busy) busy_n++;
            if (w_done) done_n++;
            if (w_product !== r_last_prod) gap_n++;
            @(negedge clk);
         end
         chk("b2b_busy_cycles", 64'(busy_n), 64'd32);
         chk("b2b_early_done",  64'(done_n), 64'd0);
         chk("b2b_prod_held",   64'(gap_n), 64'd0);
         chk("b2b_done",        64'(w_done), 64'd1);
         chk("b2b_product",     w_product, 64'd6);
         r_last_prod = 64'd6;
         if (k == 2) r_start = 1'b0;
         @(negedge clk);
         chk("b2b_next_busy", 64'(w_busy), (k < 2) ? 64'd1 : 64'd0);
      end

      // Abort mid-run with an asynchronous reset.
      r_a = 32'd5; r_b = 32'd5; r_start = 1'b1;
      @(negedge clk);
      r_start = 1'b0;
      repeat (14) @(negedge clk);
      chk("abort_busy_before", 64'(w_busy), 64'd1);
      #2 r_rst_n = 1'b0;
      #1;
      chk("abort_busy",    64'(w_busy), 64'd0);
      chk("abort_done",    64'(w_done), 64'd0);
      chk("abort_product", w_product,   64'h0);
      done_n = 0;
      repeat (2) begin
         @(negedge clk);
         if (w_done) done_n++;
      end
      chk("abort_no_done", 64'(done_n), 64'd0);
      r_rst_n = 1'b1;
      r_last_prod = 64'h0;
      run_op("m4x4", 32'd4, 32'd4, 64'd16, -1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
